// File: rtl/fanout_hash_fork.sv
// Eager/lazy ready-valid fork: broadcasts one upstream token to up to NUM_OUT consumers,
// tracking per-channel acceptance in a taken mask, and counts upstream handshakes.
module fanout_hash_fork #(
    parameter int NUM_OUT    = 9,
    parameter int DATA_WIDTH = 17,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic                          flush,
    input  logic [NUM_OUT-1:0]            cfg_enable,
    input  logic [NUM_OUT-1:0]            cfg_sel,
    input  logic                          cfg_eager,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready,
    output logic [CNT_WIDTH-1:0]          tok_count
);

    logic [NUM_OUT-1:0]   taken_q, taken_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [NUM_OUT-1:0] active;
    logic               gate;
    logic [NUM_OUT-1:0] eager_valid, eager_acc, eager_done;
    logic               eager_ready;
    logic [NUM_OUT-1:0] lazy_valid;
    logic               lazy_ready;
    logic               fire;

    assign out_data = {NUM_OUT{in_data}};

    always_comb begin
        active = cfg_enable & cfg_sel;
        gate   = clk_en & ~flush & rst_n;

        // Eager: a channel drops out of the AND once it has taken the token or takes it now.
        eager_valid = {NUM_OUT{gate & in_valid}} & active & ~taken_q;
        eager_acc   = eager_valid & out_ready;
        eager_done  = ~active | taken_q | eager_acc;
        eager_ready = gate & (&eager_done);

        lazy_ready  = gate & (&(~active | out_ready));
        lazy_valid  = {NUM_OUT{gate & in_valid & lazy_ready}} & active;

        in_ready  = cfg_eager ? eager_ready : lazy_ready;
        out_valid = cfg_eager ? eager_valid : lazy_valid;
        fire      = in_valid & in_ready;
    end

    always_comb begin
        taken_d = taken_q;
        cnt_d   = cnt_q;
        if (flush) begin
            taken_d = '0;
            cnt_d   = '0;
        end else if (clk_en) begin
            if (fire)
                cnt_d = cnt_q + CNT_WIDTH'(1);
            if (fire || !cfg_eager)
                taken_d = '0;
            else
                taken_d = taken_q | eager_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q <= '0;
            cnt_q   <= '0;
        end else begin
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tok_count = cnt_q;

endmodule

// File: tb/tb_fanout_hash_fork.sv
// Bench for fanout_hash_fork: directed scenarios plus randomized traffic against a
// per-channel "has this consumer received the current token" reference model.
module tb_fanout_hash_fork;

    localparam int N  = 9;
    localparam int DW = 17;
    localparam int CW = 4;

    logic              clk;
    logic              rst_n;
    logic              clk_en;
    logic              flush;
    logic [N-1:0]      cfg_enable;
    logic [N-1:0]      cfg_sel;
    logic              cfg_eager;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   out_data;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;
    logic [CW-1:0]     tok_count;

    fanout_hash_fork #(.NUM_OUT(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
        .cfg_enable(cfg_enable), .cfg_sel(cfg_sel), .cfg_eager(cfg_eager),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .tok_count(tok_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which consumers already hold the current token, and tokens consumed.
    bit           m_got[N];
    int           m_count;
    logic         e_ir;
    logic [N-1:0] e_ov;
    logic [CW-1:0] e_cnt;

    int n_checks;
    int n_pass;

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_got[i] = 1'b0;
        m_count = 0;
    endfunction

    function automatic void model_eval();
        bit g;
        bit all_ok;
        bit act;
        g      = clk_en && !flush && rst_n;
        all_ok = 1'b1;
        e_ov   = '0;
        for (int i = 0; i < N; i++) begin
            act = cfg_enable[i] && cfg_sel[i];
            if (cfg_eager) begin
                if (act && !m_got[i] && !(in_valid && out_ready[i])) all_ok = 1'b0;
            end else begin
                if (act && !out_ready[i]) all_ok = 1'b0;
            end
        end
        e_ir = g && all_ok;
        for (int i = 0; i < N; i++) begin
            act = cfg_enable[i] && cfg_sel[i];
            if (cfg_eager) e_ov[i] = g && in_valid && act && !m_got[i];
            else           e_ov[i] = g && in_valid && act && e_ir;
        end
        e_cnt = m_count[CW-1:0];
    endfunction

    function automatic void model_update();
        model_eval();
        if (!rst_n || flush) begin
            model_clear();
        end else if (clk_en) begin
            if (in_valid && e_ir) begin
                for (int i = 0; i < N; i++) m_got[i] = 1'b0;
                m_count++;
            end else if (cfg_eager) begin
                for (int i = 0; i < N; i++)
                    if (e_ov[i] && out_ready[i]) m_got[i] = 1'b1;
            end
        end
    endfunction

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush    = 1'b1;
        advance();
        flush    = 1'b0;
    endtask

    task automatic setup_all(input logic eager);
        cfg_enable = '1;
        cfg_sel    = '1;
        cfg_eager  = eager;
        clk_en     = 1'b1;
        out_ready  = '1;
        do_flush();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0;
        cfg_enable = '1; cfg_sel = '1; cfg_eager = 1'b1;
        out_ready = '1; in_valid = 1'b1; in_data = 17'h1abcd;
        model_clear();
        #2;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== '0 || tok_count !== '0)
            $display("FAIL reset_hold: in_ready=%b out_valid=%h tok_count=%0d, expected 0 0 0",
                     in_ready, out_valid, tok_count);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (tok_count !== '0 || in_ready !== 1'b0)
            $display("FAIL reset_edges: tok_count=%0d in_ready=%b, expected 0 0", tok_count, in_ready);
        else n_pass++;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        advance();
    endtask

    task automatic test_eager_b2b();
        setup_all(1'b1);
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            #1; model_eval();
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 9'h1ff || out_data !== {N{in_data}} || e_ov !== 9'h1ff)
                $display("FAIL eager_b2b c%0d: in_ready=%b out_valid=%h, expected 1 1ff", c, in_ready, out_valid);
            else n_pass++;
            advance();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (tok_count !== 4'd4)
            $display("FAIL eager_b2b_count: tok_count=%0d, expected 4", tok_count);
        else n_pass++;
    endtask

    task automatic test_stall(input logic eager);
        logic [N-1:0] xv[4];
        logic         xr[4];
        setup_all(eager);
        if (eager) begin
            xv = '{9'h1ff, 9'h008, 9'h008, 9'h008};
        end else begin
            xv = '{9'h000, 9'h000, 9'h000, 9'h1ff};
        end
        xr = '{1'b0, 1'b0, 1'b0, 1'b1};
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        for (int c = 0; c < 4; c++) begin
            out_ready = (c < 3) ? 9'h1f7 : 9'h1ff;
            #1; model_eval();
            n_checks++;
            if (out_valid !== xv[c] || in_ready !== xr[c] || out_valid !== e_ov || in_ready !== e_ir)
                $display("FAIL stall_%s c%0d: out_valid=%h in_ready=%b, expected %h %b",
                         eager ? "eager" : "lazy", c, out_valid, in_ready, xv[c], xr[c]);
            else n_pass++;
            advance();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (tok_count !== 4'd1 || out_valid !== '0)
            $display("FAIL stall_%s_count: tok_count=%0d out_valid=%h, expected 1 0",
                     eager ? "eager" : "lazy", tok_count, out_valid);
        else n_pass++;
    endtask

    task automatic test_no_active();
        setup_all(1'b1);
        cfg_sel = '0;
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            out_ready = N'($urandom);
            #1;
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== '0)
                $display("FAIL no_active c%0d: in_ready=%b out_valid=%h, expected 1 0", c, in_ready, out_valid);
            else n_pass++;
            advance();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (tok_count !== 4'd5)
            $display("FAIL no_active_count: tok_count=%0d, expected 5", tok_count);
        else n_pass++;
    endtask

    task automatic test_flush();
        setup_all(1'b1);
        in_valid = 1'b1;
        advance();
        out_ready = 9'h0f0;
        #1;
        n_checks++;
        if (out_valid !== 9'h1ff || in_ready !== 1'b0 || tok_count !== 4'd1)
            $display("FAIL flush_partial: out_valid=%h in_ready=%b tok_count=%0d, expected 1ff 0 1",
                     out_valid, in_ready, tok_count);
        else n_pass++;
        advance();
        out_ready = 9'h000;
        #1;
        n_checks++;
        if (out_valid !== 9'h10f || in_ready !== 1'b0)
            $display("FAIL flush_taken: out_valid=%h in_ready=%b, expected 10f 0", out_valid, in_ready);
        else n_pass++;
        flush = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== '0 || in_ready !== 1'b0)
            $display("FAIL flush_gate: out_valid=%h in_ready=%b, expected 0 0", out_valid, in_ready);
        else n_pass++;
        advance();
        flush     = 1'b0;
        out_ready = '1;
        #1;
        n_checks++;
        if (tok_count !== 4'd0 || out_valid !== 9'h1ff || in_ready !== 1'b1)
            $display("FAIL flush_after: tok_count=%0d out_valid=%h in_ready=%b, expected 0 1ff 1",
                     tok_count, out_valid, in_ready);
        else n_pass++;
        advance();
        in_valid = 1'b0;
    endtask

    task automatic test_clk_en();
        setup_all(1'b1);
        in_valid  = 1'b1;
        out_ready = 9'h00f;
        advance();
        clk_en    = 1'b0;
        out_ready = '1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (out_valid !== '0 || in_ready !== 1'b0 || tok_count !== 4'd0)
                $display("FAIL clken_low c%0d: out_valid=%h in_ready=%b tok_count=%0d, expected 0 0 0",
                         c, out_valid, in_ready, tok_count);
            else n_pass++;
            advance();
        end
        clk_en = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 9'h1f0 || in_ready !== 1'b1)
            $display("FAIL clken_resume: out_valid=%h in_ready=%b, expected 1f0 1", out_valid, in_ready);
        else n_pass++;
        advance();
        in_valid = 1'b0;
    endtask

    task automatic test_wrap();
        setup_all(1'b0);
        in_valid = 1'b1;
        for (int c = 0; c < 17; c++) advance();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (tok_count !== 4'd1)
            $display("FAIL wrap: tok_count=%0d, expected 1", tok_count);
        else n_pass++;
    endtask

    task automatic test_rst_pulse();
        setup_all(1'b1);
        in_valid  = 1'b1;
        advance();
        out_ready = 9'h003;
        advance();
        out_ready = '0;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (out_valid !== '0 || in_ready !== 1'b0 || tok_count !== 4'd0)
            $display("FAIL rst_pulse: out_valid=%h in_ready=%b tok_count=%0d, expected 0 0 0",
                     out_valid, in_ready, tok_count);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 9'h1ff || in_ready !== 1'b0)
            $display("FAIL rst_taken_cleared: out_valid=%h in_ready=%b, expected 1ff 0", out_valid, in_ready);
        else n_pass++;
        out_ready = '1;
        advance();
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        int      h_cnt[N];
        logic    fire;
        logic [N-1:0] act;
        bit      bad;
        setup_all(1'b1);
        for (int i = 0; i < N; i++) h_cnt[i] = 0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid && $urandom_range(0, 29) == 0) begin
                cfg_enable = N'($urandom);
                cfg_sel    = N'($urandom) | N'($urandom);
                cfg_eager  = 1'($urandom);
                clk_en     = 1'b1;
                do_flush();
                for (int i = 0; i < N; i++) h_cnt[i] = 0;
            end
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
            end
            out_ready = N'($urandom) | N'($urandom);
            clk_en    = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            #1; model_eval();
            n_checks++;
            if (in_ready !== e_ir || out_valid !== e_ov || tok_count !== e_cnt || out_data !== {N{in_data}})
                $display("FAIL random c%0d: in_ready=%b out_valid=%h tok_count=%0d, expected %b %h %0d",
                         c, in_ready, out_valid, tok_count, e_ir, e_ov, e_cnt);
            else n_pass++;
            for (int i = 0; i < N; i++)
                if (out_valid[i] && out_ready[i]) h_cnt[i]++;
            fire = in_valid && in_ready;
            if (fire) begin
                act = cfg_enable & cfg_sel;
                bad = 1'b0;
                for (int i = 0; i < N; i++)
                    if (h_cnt[i] != (act[i] ? 1 : 0)) bad = 1'b1;
                n_checks++;
                if (bad)
                    $display("FAIL random_once c%0d: per-channel handshakes ch0=%0d ch3=%0d ch8=%0d, expected 1 per active channel (active=%h)",
                             c, h_cnt[0], h_cnt[3], h_cnt[8], act);
                else n_pass++;
                for (int i = 0; i < N; i++) h_cnt[i] = 0;
            end
            if (flush)
                for (int i = 0; i < N; i++) h_cnt[i] = 0;
            advance();
            flush = 1'b0;
            if (fire) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        clk_en   = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_eager_b2b();
        test_stall(1'b1);
        test_stall(1'b0);
        test_no_active();
        test_flush();
        test_clk_en();
        test_wrap();
        test_rst_pulse();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1);
    end

endmodule

// File: doc/fanout_hash_fork.md
# fanout_hash_fork

Parametrised eager fork that broadcasts one upstream ready/valid stream to up to NUM_OUT downstream consumers in the SAM Onyx primitive fabric. It is the successor to the combinational fanout-ready reducer. Per consumer, an enable bit and a select bit decide whether that consumer participates. In eager mode, a registered per-channel "taken" mask lets each consumer accept the token independently, so a slow consumer no longer blocks the others' handshakes. A legacy lazy mode and a handshake counter are included for debug.

## Interface
- NUM_OUT, 9, number of downstream channels (1..16)
- DATA_WIDTH, 17, token width (data plus control bit)
- CNT_WIDTH, 16, width of the handshake counter

- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clk_en  input  1  clock enable; state holds and all handshakes are blocked when low
- flush  input  1  synchronous clear of the taken mask and counter
- cfg_enable  input  NUM_OUT  per-channel enable
- cfg_sel  input  NUM_OUT  per-channel fanout select
- cfg_eager  input  1  1 = eager fork, 0 = lazy (all-ready) fork
- in_data  input  DATA_WIDTH  upstream token
- in_valid  input  1  upstream valid
- in_ready  output  1  upstream ready
- out_data  output  NUM_OUT*DATA_WIDTH  copies of in_data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  output  NUM_OUT  per-channel valid
- out_ready  input  NUM_OUT  per-channel ready
- tok_count  output  CNT_WIDTH  number of upstream handshakes since reset or flush

## Operation
- active[i] = cfg_enable[i] & cfg_sel[i]. Inactive channels never assert out_valid, and their out_ready is ignored.
- gate = clk_en & ~flush & rst_n. When gate is 0, in_ready = 0 and out_valid = 0.
- out_data is a wire copy of in_data on every channel at all times.

Eager mode (cfg_eager = 1):
- out_valid[i] = gate & in_valid & active[i] & ~taken[i].
- acc[i] = out_valid[i] & out_ready[i].
- done[i] = ~active[i] | taken[i] | acc[i].
- in_ready = gate & AND(done).
- Register update when gate is 1:
  - If in_valid & in_ready, taken <= 0.
  - Else taken <= taken | acc.

Lazy mode (cfg_eager = 0):
- in_ready = gate & AND(~active | out_ready).
- out_valid[i] = gate & in_valid & active[i] & in_ready.
- taken is held at 0.

Counter:
- tok_count increments by 1 on each cycle with gate & in_valid & in_ready.
- It wraps from 2^CNT_WIDTH-1 to 0.

Flush and reset:
- flush has priority over clk_en and clears taken and tok_count on the next edge.
- rst_n low clears taken and tok_count asynchronously.

Boundary rules:
- No active channel: in_ready = gate. The token is consumed and dropped, and tok_count still increments.
- The final pending channel accepting in the same cycle as earlier channels completes the token in that cycle. No extra cycle is spent.
- in_valid dropped while a token is partially taken: the taken bits are retained, and the next token presented is treated as the same token. Upstream must hold valid; deasserting it is a protocol violation.
- cfg_* must be static while in_valid is high. If a channel is deactivated mid-token, its taken bit is ignored through done.
- Switching cfg_eager with taken != 0 is illegal; flush before switching.

## Timing
- Zero-latency combinational paths: out_ready to in_ready, and in_valid to out_valid.
- Lazy mode additionally has a path from out_ready to out_valid.
- Eager mode has no combinational path from out_ready[j] to out_valid[i].
- A token broadcast completes in 1 cycle when all active channels are ready. Otherwise it takes as many cycles as the slowest channel needs, and each channel sees exactly one out_valid & out_ready per token.
- Reset values:
  - taken = 0, tok_count = 0.
  - While rst_n is low, in_ready = 0 and out_valid = 0.
- The taken mask and counter update on the rising clk edge only when clk_en = 1 or flush = 1.

## Test plan
- Eager, NUM_OUT = 9, all active, all out_ready = 1, 4 back-to-back tokens -> in_ready high every cycle, each out_valid high for 4 cycles, tok_count = 4.
- Eager, channel 3 has out_ready = 0 for 3 cycles while the others are ready -> the others handshake once in cycle 0 and then have out_valid = 0. in_ready stays 0 until channel 3 is ready, then goes to 1. tok_count = 1.
- Lazy, the same stall on channel 3 -> all out_valid stay 0 until channel 3 is ready, then all assert together for 1 cycle.
- cfg_enable = 0x1FF, cfg_sel = 0 -> in_ready = 1 and out_valid = 0; 5 tokens give tok_count = 5.
- Partial accept (taken = 0x0F0), then flush for 1 cycle -> taken = 0 and tok_count = 0; the re-presented token is delivered to all 9 channels.
- clk_en = 0 mid-token -> in_ready = 0, out_valid = 0, taken held. Restoring clk_en resumes delivery only on the channels not yet taken.
- Counter wrap with CNT_WIDTH = 4 -> after 17 handshakes, tok_count = 1.
- rst_n pulsed low mid-token -> outputs go to 0 immediately and taken is cleared.
